axi4l_rr_arbiter: RTL and testbench

AXI4L_RR_ARBITER -- requirements
Module: axi4l_rr_arbiter

---
 rtl/axi4l_rr_arbiter.sv | 192 +++++++++++++++++++
 tb/tb_axi4l_rr_arbiter.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4l_rr_arbiter.sv
// rtl/axi4l_rr_arbiter.sv - two-master to one-slave AXI4-Lite round-robin arbiter
// Purpose: independent write and read arbitration of upstream ports s0/s1 onto m_*.
// Ports: clk_i/rst_ni (async active-low), s0_*/s1_* upstream AXI4-Lite slave ports,
//        m_* downstream AXI4-Lite master port. One outstanding transaction per path.
module axi4l_rr_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic [ADDR_WIDTH-1:0]   s0_awaddr_i,
    input  logic [2:0]              s0_awprot_i,
    input  logic                    s0_awvalid_i,
    output logic                    s0_awready_o,
    input  logic [DATA_WIDTH-1:0]   s0_wdata_i,
    input  logic [DATA_WIDTH/8-1:0] s0_wstrb_i,
    input  logic                    s0_wvalid_i,
    output logic                    s0_wready_o,
    output logic [1:0]              s0_bresp_o,
    output logic                    s0_bvalid_o,
    input  logic                    s0_bready_i,
    input  logic [ADDR_WIDTH-1:0]   s0_araddr_i,
    input  logic [2:0]              s0_arprot_i,
    input  logic                    s0_arvalid_i,
    output logic                    s0_arready_o,
    output logic [DATA_WIDTH-1:0]   s0_rdata_o,
    output logic [1:0]              s0_rresp_o,
    output logic                    s0_rvalid_o,
    input  logic                    s0_rready_i,
    input  logic [ADDR_WIDTH-1:0]   s1_awaddr_i,
    input  logic [2:0]              s1_awprot_i,
    input  logic                    s1_awvalid_i,
    output logic                    s1_awready_o,
    input  logic [DATA_WIDTH-1:0]   s1_wdata_i,
    input  logic [DATA_WIDTH/8-1:0] s1_wstrb_i,
    input  logic                    s1_wvalid_i,
    output logic                    s1_wready_o,
    output logic [1:0]              s1_bresp_o,
    output logic                    s1_bvalid_o,
    input  logic                    s1_bready_i,
    input  logic [ADDR_WIDTH-1:0]   s1_araddr_i,
    input  logic [2:0]              s1_arprot_i,
    input  logic                    s1_arvalid_i,
    output logic                    s1_arready_o,
    output logic [DATA_WIDTH-1:0]   s1_rdata_o,
    output logic [1:0]              s1_rresp_o,
    output logic                    s1_rvalid_o,
    input  logic                    s1_rready_i,
    output logic [ADDR_WIDTH-1:0]   m_awaddr_o,
    output logic [2:0]              m_awprot_o,
    output logic                    m_awvalid_o,
    input  logic                    m_awready_i,
    output logic [DATA_WIDTH-1:0]   m_wdata_o,
    output logic [DATA_WIDTH/8-1:0] m_wstrb_o,
    output logic                    m_wvalid_o,
    input  logic                    m_wready_i,
    input  logic [1:0]              m_bresp_i,
    input  logic                    m_bvalid_i,
    output logic                    m_bready_o,
    output logic [ADDR_WIDTH-1:0]   m_araddr_o,
    output logic [2:0]              m_arprot_o,
    output logic                    m_arvalid_o,
    input  logic                    m_arready_i,
    input  logic [DATA_WIDTH-1:0]   m_rdata_i,
    input  logic [1:0]              m_rresp_i,
    input  logic                    m_rvalid_i,
    output logic                    m_rready_o
);

    typedef enum logic [1:0] {W_IDLE = 2'd0, W_XFER = 2'd1, W_RESP = 2'd2} w_state_t;
    typedef enum logic [1:0] {R_IDLE = 2'd0, R_ADDR = 2'd1, R_RESP = 2'd2} r_state_t;

    w_state_t w_state;
    r_state_t r_state;
    logic     w_gnt, w_last, aw_done, w_done;
    logic     r_gnt, r_last;

    logic w_busy, w_xfer, w_resp, r_busy, r_addr, r_resp;
    logic w_pick, r_pick, aw_hs, w_hs;

    assign w_busy = (w_state != W_IDLE);
    assign w_xfer = (w_state == W_XFER);
    assign w_resp = (w_state == W_RESP);
    assign r_busy = (r_state != R_IDLE);
    assign r_addr = (r_state == R_ADDR);
    assign r_resp = (r_state == R_RESP);

    // On a tie the master that did not win last time on this path gets the grant.
    assign w_pick = (s0_awvalid_i & s1_awvalid_i) ? ~w_last : s1_awvalid_i;
    assign r_pick = (s0_arvalid_i & s1_arvalid_i) ? ~r_last : s1_arvalid_i;

    // Write path: downstream side, muxed from the granted master.
    assign m_awaddr_o  = !w_busy ? '0 : (w_gnt ? s1_awaddr_i : s0_awaddr_i);
    assign m_awprot_o  = !w_busy ? '0 : (w_gnt ? s1_awprot_i : s0_awprot_i);
    assign m_wdata_o   = !w_busy ? '0 : (w_gnt ? s1_wdata_i  : s0_wdata_i);
    assign m_wstrb_o   = !w_busy ? '0 : (w_gnt ? s1_wstrb_i  : s0_wstrb_i);
    // Each beat is offered once; its done flag masks repeats from the master.
    assign m_awvalid_o = w_xfer & ~aw_done & (w_gnt ? s1_awvalid_i : s0_awvalid_i);
    assign m_wvalid_o  = w_xfer & ~w_done  & (w_gnt ? s1_wvalid_i  : s0_wvalid_i);
    assign m_bready_o  = w_resp & (w_gnt ? s1_bready_i : s0_bready_i);
    assign aw_hs       = m_awvalid_o & m_awready_i;
    assign w_hs        = m_wvalid_o & m_wready_i;

    // Write path: upstream side, only the granted master sees activity.
    assign s0_awready_o = w_xfer & ~w_gnt & ~aw_done & m_awready_i;
    assign s1_awready_o = w_xfer &  w_gnt & ~aw_done & m_awready_i;
    assign s0_wready_o  = w_xfer & ~w_gnt & ~w_done & m_wready_i;
    assign s1_wready_o  = w_xfer &  w_gnt & ~w_done & m_wready_i;
    assign s0_bvalid_o  = w_resp & ~w_gnt & m_bvalid_i;
    assign s1_bvalid_o  = w_resp &  w_gnt & m_bvalid_i;
    assign s0_bresp_o   = (w_resp & ~w_gnt) ? m_bresp_i : 2'b00;
    assign s1_bresp_o   = (w_resp &  w_gnt) ? m_bresp_i : 2'b00;

    // Read path.
    assign m_araddr_o   = !r_busy ? '0 : (r_gnt ? s1_araddr_i : s0_araddr_i);
    assign m_arprot_o   = !r_busy ? '0 : (r_gnt ? s1_arprot_i : s0_arprot_i);
    assign m_arvalid_o  = r_addr & (r_gnt ? s1_arvalid_i : s0_arvalid_i);
    assign m_rready_o   = r_resp & (r_gnt ? s1_rready_i : s0_rready_i);
    assign s0_arready_o = r_addr & ~r_gnt & m_arready_i;
    assign s1_arready_o = r_addr &  r_gnt & m_arready_i;
    assign s0_rvalid_o  = r_resp & ~r_gnt & m_rvalid_i;
    assign s1_rvalid_o  = r_resp &  r_gnt & m_rvalid_i;
    assign s0_rdata_o   = (r_resp & ~r_gnt) ? m_rdata_i : '0;
    assign s1_rdata_o   = (r_resp &  r_gnt) ? m_rdata_i : '0;
    assign s0_rresp_o   = (r_resp & ~r_gnt) ? m_rresp_i : 2'b00;
    assign s1_rresp_o   = (r_resp &  r_gnt) ? m_rresp_i : 2'b00;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            w_state <= W_IDLE;
            w_gnt   <= 1'b0;
            w_last  <= 1'b1;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
        end else begin
            case (w_state)
                W_IDLE: begin
                    if (s0_awvalid_i | s1_awvalid_i) begin
                        w_gnt   <= w_pick;
                        w_last  <= w_pick;
                        w_state <= W_XFER;
                    end
                end
                W_XFER: begin
                    aw_done <= aw_done | aw_hs;
                    w_done  <= w_done | w_hs;
                    if ((aw_done | aw_hs) & (w_done | w_hs)) begin
                        w_state <= W_RESP;
                    end
                end
                W_RESP: begin
                    if (m_bvalid_i & m_bready_o) begin
                        w_state <= W_IDLE;
                        aw_done <= 1'b0;
                        w_done  <= 1'b0;
                    end
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= R_IDLE;
            r_gnt   <= 1'b0;
            r_last  <= 1'b1;
        end else begin
            case (r_state)
                R_IDLE: begin
                    if (s0_arvalid_i | s1_arvalid_i) begin
                        r_gnt   <= r_pick;
                        r_last  <= r_pick;
                        r_state <= R_ADDR;
                    end
                end
                R_ADDR: begin
                    if (m_arvalid_o & m_arready_i) begin
                        r_state <= R_RESP;
                    end
                end
                R_RESP: begin
                    if (m_rvalid_i & m_rready_o) begin
                        r_state <= R_IDLE;
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi4l_rr_arbiter.sv
// tb/tb_axi4l_rr_arbiter.sv - self-checking bench for axi4l_rr_arbiter
module tb_axi4l_rr_arbiter;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [1:0][31:0] s_awaddr, s_wdata, s_araddr, s_rdata;
    logic [1:0][2:0]  s_awprot, s_arprot;
    logic [1:0][3:0]  s_wstrb;
    logic [1:0][1:0]  s_bresp, s_rresp;
    logic [1:0] s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready;
    logic [1:0] s_arvalid, s_arready, s_rvalid, s_rready;
    logic [31:0] m_awaddr, m_wdata, m_araddr, m_rdata;
    logic [2:0]  m_awprot, m_arprot;
    logic [3:0]  m_wstrb;
    logic [1:0]  m_bresp, m_rresp;
    logic m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
    logic m_arvalid, m_arready, m_rvalid, m_rready;

    axi4l_rr_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .s0_awaddr_i(s_awaddr[0]), .s0_awprot_i(s_awprot[0]), .s0_awvalid_i(s_awvalid[0]), .s0_awready_o(s_awready[0]),
        .s0_wdata_i(s_wdata[0]), .s0_wstrb_i(s_wstrb[0]), .s0_wvalid_i(s_wvalid[0]), .s0_wready_o(s_wready[0]),
        .s0_bresp_o(s_bresp[0]), .s0_bvalid_o(s_bvalid[0]), .s0_bready_i(s_bready[0]),
        .s0_araddr_i(s_araddr[0]), .s0_arprot_i(s_arprot[0]), .s0_arvalid_i(s_arvalid[0]), .s0_arready_o(s_arready[0]),
        .s0_rdata_o(s_rdata[0]), .s0_rresp_o(s_rresp[0]), .s0_rvalid_o(s_rvalid[0]), .s0_rready_i(s_rready[0]),
        .s1_awaddr_i(s_awaddr[1]), .s1_awprot_i(s_awprot[1]), .s1_awvalid_i(s_awvalid[1]), .s1_awready_o(s_awready[1]),
        .s1_wdata_i(s_wdata[1]), .s1_wstrb_i(s_wstrb[1]), .s1_wvalid_i(s_wvalid[1]), .s1_wready_o(s_wready[1]),
        .s1_bresp_o(s_bresp[1]), .s1_bvalid_o(s_bvalid[1]), .s1_bready_i(s_bready[1]),
        .s1_araddr_i(s_araddr[1]), .s1_arprot_i(s_arprot[1]), .s1_arvalid_i(s_arvalid[1]), .s1_arready_o(s_arready[1]),
        .s1_rdata_o(s_rdata[1]), .s1_rresp_o(s_rresp[1]), .s1_rvalid_o(s_rvalid[1]), .s1_rready_i(s_rready[1]),
        .m_awaddr_o(m_awaddr), .m_awprot_o(m_awprot), .m_awvalid_o(m_awvalid), .m_awready_i(m_awready),
        .m_wdata_o(m_wdata), .m_wstrb_o(m_wstrb), .m_wvalid_o(m_wvalid), .m_wready_i(m_wready),
        .m_bresp_i(m_bresp), .m_bvalid_i(m_bvalid), .m_bready_o(m_bready),
        .m_araddr_o(m_araddr), .m_arprot_o(m_arprot), .m_arvalid_o(m_arvalid), .m_arready_i(m_arready),
        .m_rdata_i(m_rdata), .m_rresp_i(m_rresp), .m_rvalid_i(m_rvalid), .m_rready_o(m_rready)
    );

    int checks = 0;
    int failures = 0;

    // Reference model: each path is either free or owned by one master; an owned
    // write path still owes an address beat and/or a data beat, then a response.
    logic wb, wo, need_aw, need_w, w_prev;
    logic rb, ro, need_ar, r_prev;
    logic w_rsp, r_rsp;
    logic e_m_awvalid, e_m_wvalid, e_m_bready, e_m_arvalid, e_m_rready;
    logic [31:0] e_m_awaddr, e_m_wdata, e_m_araddr;
    logic [2:0]  e_m_awprot, e_m_arprot;
    logic [3:0]  e_m_wstrb;
    logic [1:0]  e_s_awready, e_s_wready, e_s_bvalid, e_s_arready, e_s_rvalid;
    logic [1:0][1:0]  e_s_bresp, e_s_rresp;
    logic [1:0][31:0] e_s_rdata;

    assign w_rsp       = wb & ~need_aw & ~need_w;
    assign r_rsp       = rb & ~need_ar;
    assign e_m_awvalid = wb & need_aw & s_awvalid[wo];
    assign e_m_wvalid  = wb & need_w & s_wvalid[wo];
    assign e_m_awaddr  = wb ? s_awaddr[wo] : 32'h0;
    assign e_m_awprot  = wb ? s_awprot[wo] : 3'h0;
    assign e_m_wdata   = wb ? s_wdata[wo] : 32'h0;
    assign e_m_wstrb   = wb ? s_wstrb[wo] : 4'h0;
    assign e_m_bready  = w_rsp & s_bready[wo];
    assign e_s_awready = {wb & wo & need_aw & m_awready, wb & ~wo & need_aw & m_awready};
    assign e_s_wready  = {wb & wo & need_w & m_wready, wb & ~wo & need_w & m_wready};
    assign e_s_bvalid  = {w_rsp & wo & m_bvalid, w_rsp & ~wo & m_bvalid};
    assign e_s_bresp[1] = (w_rsp & wo) ? m_bresp : 2'b00;
    assign e_s_bresp[0] = (w_rsp & ~wo) ? m_bresp : 2'b00;
    assign e_m_arvalid = rb & need_ar & s_arvalid[ro];
    assign e_m_araddr  = rb ? s_araddr[ro] : 32'h0;
    assign e_m_arprot  = rb ? s_arprot[ro] : 3'h0;
    assign e_m_rready  = r_rsp & s_rready[ro];
    assign e_s_arready = {rb & ro & need_ar & m_arready, rb & ~ro & need_ar & m_arready};
    assign e_s_rvalid  = {r_rsp & ro & m_rvalid, r_rsp & ~ro & m_rvalid};
    assign e_s_rdata[1] = (r_rsp & ro) ? m_rdata : 32'h0;
    assign e_s_rdata[0] = (r_rsp & ~ro) ? m_rdata : 32'h0;
    assign e_s_rresp[1] = (r_rsp & ro) ? m_rresp : 2'b00;
    assign e_s_rresp[0] = (r_rsp & ~ro) ? m_rresp : 2'b00;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb <= 1'b0; wo <= 1'b0; need_aw <= 1'b0; need_w <= 1'b0; w_prev <= 1'b1;
            rb <= 1'b0; ro <= 1'b0; need_ar <= 1'b0; r_prev <= 1'b1;
        end else begin
            if (!wb) begin
                if (|s_awvalid) begin
                    wb      <= 1'b1;
                    wo      <= (&s_awvalid) ? ~w_prev : s_awvalid[1];
                    w_prev  <= (&s_awvalid) ? ~w_prev : s_awvalid[1];
                    need_aw <= 1'b1;
                    need_w  <= 1'b1;
                end
            end else if (need_aw | need_w) begin
                if (e_m_awvalid & m_awready) need_aw <= 1'b0;
                if (e_m_wvalid & m_wready) need_w <= 1'b0;
            end else if (m_bvalid & s_bready[wo]) begin
                wb <= 1'b0;
            end
            if (!rb) begin
                if (|s_arvalid) begin
                    rb      <= 1'b1;
                    ro      <= (&s_arvalid) ? ~r_prev : s_arvalid[1];
                    r_prev  <= (&s_arvalid) ? ~r_prev : s_arvalid[1];
                    need_ar <= 1'b1;
                end
            end else if (need_ar) begin
                if (e_m_arvalid & m_arready) need_ar <= 1'b0;
            end else if (m_rvalid & s_rready[ro]) begin
                rb <= 1'b0;
            end
        end
    end

    // Handshake counters on the downstream port.
    int cyc = 0, aw_hs_n = 0, w_hs_n = 0, b_hs_n = 0, aw_hs_t = 0, w_hs_t = 0;
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst_n) begin
            if (m_awvalid & m_awready) begin aw_hs_n <= aw_hs_n + 1; aw_hs_t <= cyc; end
            if (m_wvalid & m_wready) begin w_hs_n <= w_hs_n + 1; w_hs_t <= cyc; end
            if (m_bvalid & m_bready) b_hs_n <= b_hs_n + 1;
        end
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic model_check();
        chk("model_wr_down", 128'({m_awvalid, m_awaddr, m_awprot, m_wvalid, m_wdata, m_wstrb, m_bready}),
            128'({e_m_awvalid, e_m_awaddr, e_m_awprot, e_m_wvalid, e_m_wdata, e_m_wstrb, e_m_bready}));
        chk("model_wr_up", 128'({s_awready, s_wready, s_bvalid, s_bresp}),
            128'({e_s_awready, e_s_wready, e_s_bvalid, e_s_bresp}));
        chk("model_rd_down", 128'({m_arvalid, m_araddr, m_arprot, m_rready}),
            128'({e_m_arvalid, e_m_araddr, e_m_arprot, e_m_rready}));
        chk("model_rd_up", 128'({s_arready, s_rvalid, s_rdata, s_rresp}),
            128'({e_s_arready, e_s_rvalid, e_s_rdata, e_s_rresp}));
    endtask

    // Inputs change 1 time unit after a rising edge; the model is compared at the falling edge.
    task automatic tick();
        @(negedge clk);
        model_check();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        s_awaddr = {32'h14, 32'h10};
        s_wdata  = {32'h5A5A5A5A, 32'hA5A5A5A5};
        s_wstrb  = {4'hF, 4'hF};
        s_awprot = '0; s_arprot = '0;
        s_araddr = {32'h20, 32'h30};
        s_awvalid = 2'b00; s_wvalid = 2'b00; s_arvalid = 2'b00;
        s_bready = 2'b11; s_rready = 2'b11;
        m_awready = 1'b0; m_wready = 1'b0; m_arready = 1'b0;
        m_bvalid = 1'b0; m_bresp = 2'b00;
        m_rvalid = 1'b0; m_rresp = 2'b00; m_rdata = 32'h0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_inputs();
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic       rst;
        logic [1:0] awv, wv;
        logic       mrdy, bv;
        logic [1:0] e_awready, e_wready, e_bvalid;
        logic       e_mawv, e_mwv, e_mbready;
        logic [31:0] e_awaddr;
    } wrow_t;

    wrow_t tbl[16];
    int base_aw, base_w, base_b;
    logic hs;
    logic [31:0] ar_log[$];
    int ar_t[$];

    initial begin
        clear_inputs();
        //               rst  awv    wv     mrdy  bv    awrdy  wrdy   bval   mawv  mwv   mbrdy awaddr
        tbl[0]  = '{1'b1, 2'b01, 2'b01, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 32'h0};
        tbl[1]  = '{1'b0, 2'b01, 2'b01, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 32'h0};
        tbl[2]  = '{1'b0, 2'b01, 2'b01, 1'b1, 1'b0, 2'b01, 2'b01, 2'b00, 1'b1, 1'b1, 1'b0, 32'h10};
        tbl[3]  = '{1'b0, 2'b00, 2'b00, 1'b1, 1'b1, 2'b00, 2'b00, 2'b01, 1'b0, 1'b0, 1'b1, 32'h10};
        tbl[4]  = '{1'b1, 2'b00, 2'b00, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 32'h0};
        tbl[5]  = '{1'b0, 2'b11, 2'b11, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 32'h0};
        tbl[6]  = '{1'b0, 2'b11, 2'b11, 1'b1, 1'b0, 2'b01, 2'b01, 2'b00, 1'b1, 1'b1, 1'b0, 32'h10};
        tbl[7]  = '{1'b0, 2'b10, 2'b10, 1'b1, 1'b1, 2'b00, 2'b00, 2'b01, 1'b0, 1'b0, 1'b1, 32'h10};
        tbl[8]  = '{1'b0, 2'b10, 2'b10, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 32'h0};
        tbl[9]  = '{1'b0, 2'b10, 2'b10, 1'b1, 1'b0, 2'b10, 2'b10, 2'b00, 1'b1, 1'b1, 1'b0, 32'h14};
        tbl[10] = '{1'b0, 2'b00, 2'b00, 1'b1, 1'b1, 2'b00, 2'b00, 2'b10, 1'b0, 1'b0, 1'b1, 32'h14};
        tbl[11] = '{1'b0, 2'b11, 2'b11, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 32'h0};
        tbl[12] = '{1'b0, 2'b11, 2'b11, 1'b1, 1'b0, 2'b01, 2'b01, 2'b00, 1'b1, 1'b1, 1'b0, 32'h10};
        tbl[13] = '{1'b0, 2'b10, 2'b10, 1'b1, 1'b1, 2'b00, 2'b00, 2'b01, 1'b0, 1'b0, 1'b1, 32'h10};
        tbl[14] = '{1'b0, 2'b10, 2'b10, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 32'h0};
        tbl[15] = '{1'b0, 2'b10, 2'b10, 1'b1, 1'b0, 2'b10, 2'b10, 2'b00, 1'b1, 1'b1, 1'b0, 32'h14};

        do_reset();
        for (int i = 0; i < 16; i++) begin
            rst_n = ~tbl[i].rst;
            s_awvalid = tbl[i].awv; s_wvalid = tbl[i].wv;
            m_awready = tbl[i].mrdy; m_wready = tbl[i].mrdy; m_bvalid = tbl[i].bv;
            #2;
            chk($sformatf("tbl%0d_up", i), 128'({s_awready, s_wready, s_bvalid}),
                128'({tbl[i].e_awready, tbl[i].e_wready, tbl[i].e_bvalid}));
            chk($sformatf("tbl%0d_down", i), 128'({m_awvalid, m_wvalid, m_bready, m_awaddr}),
                128'({tbl[i].e_mawv, tbl[i].e_mwv, tbl[i].e_mbready, tbl[i].e_awaddr}));
            chk($sformatf("tbl%0d_bresp", i), 128'({s_bresp, s_arready, s_rvalid}), 128'(0));
            tick();
        end

        // AW accepted 3 cycles after W: one beat of each reaches m_, one response.
        do_reset();
        base_aw = aw_hs_n; base_w = w_hs_n; base_b = b_hs_n;
        s_awvalid = 2'b01; s_wvalid = 2'b01; m_wready = 1'b1; m_awready = 1'b0;
        tick();
        #2 chk("aw_late_c1", 128'({m_awvalid, m_wvalid, s_awready[0], s_wready[0]}), 128'(4'b1101));
        tick();
        #2 chk("aw_late_wdone", 128'({m_awvalid, m_wvalid, s_wready[0]}), 128'(3'b100));
        tick();
        tick();
        m_awready = 1'b1;
        #2 chk("aw_late_awrdy", 128'({m_awvalid, s_awready}), 128'(3'b101));
        tick();
        s_awvalid = 2'b00; s_wvalid = 2'b00; m_bvalid = 1'b1;
        #2 chk("aw_late_b", 128'({s_bvalid, m_awvalid, m_wvalid}), 128'(4'b0100));
        tick();
        m_bvalid = 1'b0;
        tick();
        tick();
        chk("aw_late_counts", 128'({8'(aw_hs_n - base_aw), 8'(w_hs_n - base_w), 8'(b_hs_n - base_b)}),
            128'({8'd1, 8'd1, 8'd1}));
        chk("aw_late_order", 128'(w_hs_t < aw_hs_t), 128'(1));

        // Concurrent s0 write and s1 read.
        do_reset();
        s_awvalid = 2'b01; s_wvalid = 2'b01; s_arvalid = 2'b10;
        m_awready = 1'b1; m_wready = 1'b1; m_arready = 1'b1;
        m_bvalid = 1'b1; m_rvalid = 1'b1; m_rdata = 32'hDEADBEEF;
        tick();
        #2 chk("concur_overlap", 128'({m_awvalid, m_arvalid, m_araddr, s_bvalid, s_rvalid}),
               128'({1'b1, 1'b1, 32'h20, 2'b00, 2'b00}));
        tick();
        s_awvalid = 2'b00; s_wvalid = 2'b00; s_arvalid = 2'b00;
        #2 chk("concur_resp", 128'({s_bvalid, s_rvalid, s_rdata[1], s_rdata[0]}),
               128'({2'b01, 2'b10, 32'hDEADBEEF, 32'h0}));
        tick();
        m_bvalid = 1'b0; m_rvalid = 1'b0;
        tick();

        // Reset while the write path waits on its response.
        do_reset();
        s_awvalid = 2'b01; s_wvalid = 2'b01; m_awready = 1'b1; m_wready = 1'b1; s_bready = 2'b00;
        tick();
        tick();
        s_awvalid = 2'b00; s_wvalid = 2'b00; m_bvalid = 1'b1;
        #2 chk("rst_resp_pre", 128'(s_bvalid), 128'(2'b01));
        rst_n = 1'b0;
        #1 chk("rst_resp_now", 128'({m_awvalid, m_wvalid, m_bready, s_bvalid, s_awready, s_wready, m_arvalid, s_rvalid}),
               128'(0));
        tick();
        tick();
        rst_n = 1'b1;
        s_bready = 2'b11; s_awvalid = 2'b10; s_wvalid = 2'b10;
        #2 chk("rst_idle_nob", 128'({m_awvalid, m_bready, s_bvalid}), 128'(0));
        tick();
        #2 chk("rst_s1_grant", 128'({m_awvalid, m_awaddr, s_awready}), 128'({1'b1, 32'h14, 2'b10}));
        tick();

        // Back-to-back s0 reads with an always-ready slave.
        do_reset();
        s_araddr[0] = 32'h100; s_arvalid = 2'b01; m_arready = 1'b1; m_rvalid = 1'b1;
        for (int i = 0; i < 12; i++) begin
            #2;
            if (m_arvalid & m_arready) begin
                ar_log.push_back(m_araddr);
                ar_t.push_back(i);
            end
            hs = s_arready[0];
            tick();
            if (hs) s_araddr[0] = s_araddr[0] + 32'd4;
        end
        chk("b2b_count", 128'(ar_log.size()), 128'(4));
        for (int k = 0; k < ar_log.size(); k++) begin
            chk($sformatf("b2b_addr%0d", k), 128'(ar_log[k]), 128'(32'h100 + 32'(4 * k)));
            chk($sformatf("b2b_time%0d", k), 128'(ar_t[k]), 128'(1 + 3 * k));
        end

        // Random stimulus against the reference model, with one reset in the middle.
        do_reset();
        for (int i = 0; i < 600; i++) begin
            rst_n = (i != 300);
            s_awvalid = 2'($urandom); s_wvalid = 2'($urandom); s_arvalid = 2'($urandom);
            s_bready = 2'($urandom); s_rready = 2'($urandom);
            for (int n = 0; n < 2; n++) begin
                s_awaddr[n] = $urandom; s_wdata[n] = $urandom; s_araddr[n] = $urandom;
                s_awprot[n] = 3'($urandom); s_arprot[n] = 3'($urandom); s_wstrb[n] = 4'($urandom);
            end
            m_awready = 1'($urandom); m_wready = 1'($urandom); m_arready = 1'($urandom);
            m_bvalid = 1'($urandom); m_rvalid = 1'($urandom);
            m_bresp = 2'($urandom); m_rresp = 2'($urandom); m_rdata = $urandom;
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
